alu_arbiter: RTL and testbench

Shares the single combinational ALU of the in-order core between NUM_REQ requesters (integer issue, address generation, branch compare). Each cycle it picks at most one valid request by round-robin, drives that request's operands and function code onto the ALU inputs, and captures the ALU result into a one-entry response register with valid/ready back-pressure. It sits between the issue stage and the `alu` instance, which it drives through the `alu_op1`/`alu_op2`/`alu_func`/`alu_out` ports.

---
 rtl/alu_arbiter.sv | 106 ++++++++++
 tb/tb_alu_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin share of one combinational ALU among NUM_REQ requesters; result lands in a
// one-entry response register the cycle after the grant. A held response (rsp_valid && !rsp_ready) blocks all grants.
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 4,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_op1,
  input  logic [NUM_REQ*WIDTH-1:0] req_op2,
  input  logic [NUM_REQ*4-1:0]     req_func,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  output logic [WIDTH-1:0]         alu_op1,
  output logic [WIDTH-1:0]         alu_op2,
  output logic [3:0]               alu_func,
  input  logic [WIDTH-1:0]         alu_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_err
);

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] data;
    logic             err;
  } rsp_t;

  rsp_t             rsp_q;
  logic             rsp_vld_q;
  logic [ID_W-1:0]  rr_ptr;
  logic             can_issue;
  logic             grant_vld;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W-1:0]  cand;
  logic [TAG_W-1:0] grant_tag;
  logic             illegal;

  assign can_issue = rst_n && (!rsp_vld_q || rsp_ready);

  // Scan downward so the candidate closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    if (can_issue) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
        if (req_valid[cand]) begin
          grant_vld = 1'b1;
          grant_id  = cand;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    alu_op1   = '0;
    alu_op2   = '0;
    alu_func  = '0;
    grant_tag = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_vld && grant_id == ID_W'(i)) begin
        req_ready[i] = 1'b1;
        alu_op1      = req_op1[i*WIDTH +: WIDTH];
        alu_op2      = req_op2[i*WIDTH +: WIDTH];
        alu_func     = req_func[i*4 +: 4];
        grant_tag    = req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  assign illegal = (alu_func > 4'd10);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      rsp_vld_q <= 1'b0;
      rsp_q     <= '0;
    end else if (grant_vld) begin
      rsp_vld_q  <= 1'b1;
      rsp_q.id   <= grant_id;
      rsp_q.tag  <= grant_tag;
      rsp_q.data <= illegal ? '0 : alu_out;
      rsp_q.err  <= illegal;
      rr_ptr     <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    end else if (rsp_ready) begin
      rsp_vld_q <= 1'b0;
    end
  end

  assign rsp_valid = rsp_vld_q;
  assign rsp_id    = rsp_q.id;
  assign rsp_tag   = rsp_q.tag;
  assign rsp_data  = rsp_q.data;
  assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter (NUM_REQ=4) against a cycle-level reference model.
module tb_alu_arbiter;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int TW = 4;
  localparam int IW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_op1, req_op2;
  logic [N*4-1:0]  req_func;
  logic [N*TW-1:0] req_tag;
  logic [W-1:0]    alu_op1, alu_op2, alu_out;
  logic [3:0]      alu_func;
  logic            rsp_valid, rsp_ready, rsp_err;
  logic [IW-1:0]   rsp_id;
  logic [TW-1:0]   rsp_tag;
  logic [W-1:0]    rsp_data;

  logic [W-1:0]  op1 [N];
  logic [W-1:0]  op2 [N];
  logic [3:0]    func[N];
  logic [TW-1:0] tag [N];

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_ptr;
  bit          m_vld;
  int          m_id;
  logic [TW-1:0] m_tag;
  logic [W-1:0]  m_data;
  bit          m_err;
  logic [N-1:0] last_rdy;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_op1[i*W +: W]    = op1[i];
      req_op2[i*W +: W]    = op2[i];
      req_func[i*4 +: 4]   = func[i];
      req_tag[i*TW +: TW]  = tag[i];
    end
  end

  function automatic logic [W-1:0] ref_alu(logic [W-1:0] a, logic [W-1:0] b, logic [3:0] f);
    case (f)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return W'($signed(a) >>> b[4:0]);
      4'd8:    return {31'b0, $signed(a) < $signed(b)};
      4'd9:    return {31'b0, a < b};
      4'd10:   return b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_out = ref_alu(alu_op1, alu_op2, alu_func);

  alu_arbiter #(.WIDTH(W), .NUM_REQ(N), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_func(req_func), .req_tag(req_tag),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_func(alu_func), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_tag(rsp_tag), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int ref_grant();
    if (!rst_n) return -1;
    if (m_vld && !rsp_ready) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // Inputs are already applied; compare outputs, then step model and DUT one edge.
  task automatic cycle();
    int g;
    #1;
    g = ref_grant();
    check_eq("req_ready", req_ready, (g < 0) ? 0 : (64'd1 << g));
    check_eq("alu_op1",   alu_op1,   (g < 0) ? 0 : op1[g]);
    check_eq("alu_op2",   alu_op2,   (g < 0) ? 0 : op2[g]);
    check_eq("alu_func",  alu_func,  (g < 0) ? 0 : func[g]);
    check_eq("rsp_valid", rsp_valid, m_vld);
    check_eq("rsp_id",    rsp_id,    m_id);
    check_eq("rsp_tag",   rsp_tag,   m_tag);
    check_eq("rsp_data",  rsp_data,  m_data);
    check_eq("rsp_err",   rsp_err,   m_err);
    last_rdy = req_ready;
    @(posedge clk);
    if (!rst_n) begin
      m_ptr = 0; m_vld = 0; m_id = 0; m_tag = 0; m_data = 0; m_err = 0;
    end else if (g >= 0) begin
      m_vld  = 1;
      m_id   = g;
      m_tag  = tag[g];
      m_err  = (func[g] > 4'd10);
      m_data = m_err ? '0 : ref_alu(op1[g], op2[g], func[g]);
      m_ptr  = (g + 1) % N;
    end else if (rsp_ready) begin
      m_vld = 0;
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] f, input logic [TW-1:0] t);
    op1[i] = a; op2[i] = b; func[i] = f; tag[i] = t;
  endtask

  initial begin
    logic [W-1:0]  held_data;
    logic [TW-1:0] held_tag;
    rst_n = 1'b0; req_valid = '1; rsp_ready = 1'b1; last_rdy = '0;
    m_ptr = 0; m_vld = 0; m_id = 0; m_tag = 0; m_data = 0; m_err = 0;
    for (int i = 0; i < N; i++) set_req(i, W'(i + 7), W'(i + 3), 4'(i), TW'(i));
    @(negedge clk);
    cycle();
    cycle();
    check_eq("reset_ready", last_rdy, 0);

    // single op
    rst_n = 1'b1; req_valid = 4'b0001;
    set_req(0, 1, 2, 4'd1, 4'd3);
    cycle();
    check_eq("single_grant", last_rdy, 4'b0001);
    req_valid = '0;
    check_eq("single_data", rsp_data, 32'hFFFF_FFFF);
    check_eq("single_tag", rsp_tag, 4'd3);
    cycle();
    check_eq("single_drain", rsp_valid, 0);

    // fairness between req0 and req1
    req_valid = 4'b0011;
    for (int c = 0; c < 6; c++) begin
      set_req(0, W'($urandom), W'($urandom), 4'($urandom_range(0, 10)), 4'($urandom));
      set_req(1, W'($urandom), W'($urandom), 4'($urandom_range(0, 10)), 4'($urandom));
      cycle();
      check_eq("fair_grant", last_rdy, (c % 2 == 0) ? 4'b0010 : 4'b0001);
      check_eq("fair_id", rsp_id, (c % 2 == 0) ? 1 : 0);
    end
    req_valid = '0;
    cycle();

    // back-pressure
    req_valid = 4'b0001;
    cycle();
    rsp_ready = 1'b0; req_valid = 4'b0011;
    held_data = rsp_data; held_tag = rsp_tag;
    for (int c = 0; c < 5; c++) begin
      cycle();
      check_eq("bp_ready", last_rdy, 0);
    end
    check_eq("bp_data_hold", rsp_data, held_data);
    check_eq("bp_tag_hold", rsp_tag, held_tag);
    rsp_ready = 1'b1;
    cycle();
    check_eq("bp_reload_vld", rsp_valid, 1);
    check_eq("bp_reload_id", rsp_id, 1);
    req_valid = '0;
    cycle();

    // illegal function code then legal one
    req_valid = 4'b0010;
    set_req(1, 5, 5, 4'd12, 4'd9);
    cycle();
    check_eq("illegal_err", rsp_err, 1);
    check_eq("illegal_data", rsp_data, 0);
    check_eq("illegal_id", rsp_id, 1);
    set_req(1, 5, 5, 4'd0, 4'd2);
    cycle();
    check_eq("legal_err", rsp_err, 0);
    check_eq("legal_data", rsp_data, 10);
    req_valid = '0;
    cycle();

    // reset with a pending response; rr_ptr is 1 before the reset
    rsp_ready = 1'b0; req_valid = 4'b0001;
    cycle();
    req_valid = '0;
    rst_n = 1'b0;
    cycle();
    check_eq("rst_mid_vld", rsp_valid, 0);
    rst_n = 1'b1; rsp_ready = 1'b1; req_valid = 4'b0011;
    cycle();
    check_eq("rst_first_grant", last_rdy, 4'b0001);
    req_valid = '0;
    cycle();

    // wrap-around
    req_valid = 4'b1000;
    cycle();
    check_eq("wrap_g3", last_rdy, 4'b1000);
    req_valid = 4'b0101;
    cycle();
    check_eq("wrap_g0", last_rdy, 4'b0001);
    cycle();
    check_eq("wrap_g2", last_rdy, 4'b0100);
    req_valid = '0;
    cycle();

    // randomized traffic; pending requests hold their fields
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && !last_rdy[i])) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          set_req(i, W'($urandom), W'($urandom), 4'($urandom_range(0, 15)), 4'($urandom));
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 99) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
